// File: rtl/rv_id_buffer_if.sv
// Fetch-to-decode handshake bundle for rv_id_buffer: push channel, pop channel, flush.
interface rv_id_buffer_if;
  logic        if_valid_i;
  logic [31:0] if_instr_i;
  logic [63:0] if_pc_i;
  logic        if_ready_o;
  logic        flush_i;
  logic        id_valid_o;
  logic        id_ready_i;
  logic [31:0] id_instr_o;
  logic [63:0] id_pc_o;
  logic [63:0] id_imm_o;
  logic [2:0]  id_fmt_o;

  modport slave (
    input  if_valid_i, if_instr_i, if_pc_i, flush_i, id_ready_i,
    output if_ready_o, id_valid_o, id_instr_o, id_pc_o, id_imm_o, id_fmt_o
  );

  modport master (
    output if_valid_i, if_instr_i, if_pc_i, flush_i, id_ready_i,
    input  if_ready_o, id_valid_o, id_instr_o, id_pc_o, id_imm_o, id_fmt_o
  );
endinterface

// File: rtl/rv_id_buffer.sv
// Two-entry head+skid buffer between fetch and decode; immediate and format are
// decoded at push time so the outputs come straight from registers.
//
//   state   | meaning
//   S_EMPTY | no entry held, id_valid_o low
//   S_ONE   | head valid, skid free
//   S_TWO   | head and skid valid, fetch stalled
module rv_id_buffer (
  input  logic           clk_i,
  input  logic           rst_i,
  rv_id_buffer_if.slave  bus
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [63:0] pc;
    logic [63:0] imm;
    logic [2:0]  fmt;
  } entry_t;

  state_t      r_state;
  state_t      w_state_nxt;
  entry_t      r_head;
  entry_t      r_skid;
  entry_t      w_new;
  logic        r_ready;
  logic        w_push;
  logic        w_pop;
  logic        w_load_head_new;
  logic        w_load_head_skid;
  logic        w_load_skid;
  logic [31:0] w_instr;
  logic        w_sign;

  assign w_instr = bus.if_instr_i;
  assign w_sign  = w_instr[31];
  assign w_push  = bus.if_valid_i && r_ready;
  assign w_pop   = (r_state != S_EMPTY) && bus.id_ready_i;

  always_comb begin
    w_new.instr = w_instr;
    w_new.pc    = bus.if_pc_i;
    w_new.imm   = '0;
    w_new.fmt   = 3'd7;
    case (w_instr[6:0])
      7'b0000011, 7'b0010011, 7'b0011011, 7'b1100111, 7'b1110011: begin
        w_new.fmt = 3'd1;
        w_new.imm = {{52{w_sign}}, w_instr[31:20]};
      end
      7'b0100011: begin
        w_new.fmt = 3'd2;
        w_new.imm = {{52{w_sign}}, w_instr[31:25], w_instr[11:7]};
      end
      7'b1100011: begin
        w_new.fmt = 3'd3;
        w_new.imm = {{51{w_sign}}, w_instr[31], w_instr[7], w_instr[30:25],
                     w_instr[11:8], 1'b0};
      end
      7'b0110111, 7'b0010111: begin
        w_new.fmt = 3'd4;
        w_new.imm = {{32{w_sign}}, w_instr[31:12], 12'b0};
      end
      7'b1101111: begin
        w_new.fmt = 3'd5;
        w_new.imm = {{43{w_sign}}, w_instr[31], w_instr[19:12], w_instr[20],
                     w_instr[30:21], 1'b0};
      end
      7'b0110011, 7'b0111011: begin
        w_new.fmt = 3'd0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_EMPTY;
      r_ready <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_ready <= (w_state_nxt != S_TWO);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (bus.flush_i) begin
      w_state_nxt = S_EMPTY;
    end else begin
      case (r_state)
        S_EMPTY: if (w_push) w_state_nxt = S_ONE;
        S_ONE: begin
          if (w_push && !w_pop)      w_state_nxt = S_TWO;
          else if (!w_push && w_pop) w_state_nxt = S_EMPTY;
        end
        S_TWO:   if (w_pop) w_state_nxt = S_ONE;
        default: w_state_nxt = S_EMPTY;
      endcase
    end
  end

  // Head takes the new word when it would otherwise be empty after this edge.
  assign w_load_head_new  = !bus.flush_i && w_push &&
                            ((r_state == S_EMPTY) || (r_state == S_ONE && w_pop));
  assign w_load_head_skid = !bus.flush_i && w_pop && (r_state == S_TWO);
  assign w_load_skid      = !bus.flush_i && w_push && !w_pop && (r_state == S_ONE);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_head <= '0;
      r_skid <= '0;
    end else begin
      if (w_load_head_new)       r_head <= w_new;
      else if (w_load_head_skid) r_head <= r_skid;
      if (w_load_skid)           r_skid <= w_new;
    end
  end

  always_comb begin
    bus.if_ready_o = r_ready;
    bus.id_valid_o = (r_state != S_EMPTY);
    bus.id_instr_o = r_head.instr;
    bus.id_pc_o    = r_head.pc;
    bus.id_imm_o   = r_head.imm;
    bus.id_fmt_o   = r_head.fmt;
  end

endmodule

// File: tb/tb_rv_id_buffer.sv
// Directed and randomized checks of rv_id_buffer against a scoreboard of
// independently decoded entries.
module tb_rv_id_buffer;

  typedef struct {
    logic [31:0] instr;
    logic [63:0] pc;
    logic [63:0] imm;
    logic [2:0]  fmt;
  } entry_t;

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  int     tests = 0;
  int     fails = 0;
  bit     chk_en = 1'b0;
  bit     stall_prev = 1'b0;
  entry_t prev;
  entry_t q[$];

  rv_id_buffer_if bus ();

  rv_id_buffer dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Arithmetic reconstruction of the immediate from the sign-extended word.
  function automatic entry_t model(input logic [31:0] ins, input logic [63:0] pc);
    entry_t      e;
    longint      sx;
    longint      sh;
    logic [63:0] t;
    sx = longint'($signed(ins));
    e.instr = ins;
    e.pc    = pc;
    e.imm   = 64'd0;
    e.fmt   = 3'd7;
    case (ins[6:0])
      7'h03, 7'h13, 7'h1B, 7'h67, 7'h73: begin
        e.fmt = 3'd1;
        sh = sx >>> 20;
        e.imm = sh;
      end
      7'h23: begin
        e.fmt = 3'd2;
        sh = sx >>> 20;
        t = sh;
        e.imm = (t & ~64'h1F) | 64'(ins[11:7]);
      end
      7'h63: begin
        e.fmt = 3'd3;
        sh = sx >>> 19;
        t = sh;
        e.imm = (t & ~64'hFFF) | (64'(ins[7]) << 11) | (64'(ins[30:25]) << 5)
                | (64'(ins[11:8]) << 1);
      end
      7'h37, 7'h17: begin
        e.fmt = 3'd4;
        t = sx;
        e.imm = t & ~64'hFFF;
      end
      7'h6F: begin
        e.fmt = 3'd5;
        sh = sx >>> 11;
        t = sh;
        e.imm = (t & ~64'hFFFFF) | 64'(ins & 32'h000FF000) | (64'(ins[20]) << 11)
                | (64'(ins[30:21]) << 1);
      end
      7'h33, 7'h3B: e.fmt = 3'd0;
      default: ;
    endcase
    return e;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [63:0] pc);
    bus.if_valid_i = v;
    bus.if_instr_i = ins;
    bus.if_pc_i    = pc;
  endtask

  // One clock: sample at negedge, update scoreboard, then step to #1 after posedge.
  task automatic cycle();
    entry_t e;
    bit     push_m;
    bit     pop_m;
    @(negedge clk);
    if (chk_en) begin
      check("id_valid", 64'(bus.id_valid_o), 64'(q.size() != 0));
      check("if_ready", 64'(bus.if_ready_o), 64'(q.size() < 2));
      if (stall_prev) begin
        check("hold_instr", 64'(bus.id_instr_o), 64'(prev.instr));
        check("hold_pc", bus.id_pc_o, prev.pc);
        check("hold_imm", bus.id_imm_o, prev.imm);
        check("hold_fmt", 64'(bus.id_fmt_o), 64'(prev.fmt));
      end
    end
    push_m = bus.if_valid_i && (q.size() < 2);
    pop_m  = (q.size() != 0) && bus.id_ready_i;
    stall_prev = !rst && !bus.flush_i && (q.size() != 0) && !bus.id_ready_i;
    prev.instr = bus.id_instr_o;
    prev.pc    = bus.id_pc_o;
    prev.imm   = bus.id_imm_o;
    prev.fmt   = bus.id_fmt_o;
    if (rst) begin
      q.delete();
    end else begin
      if (pop_m) begin
        e = q.pop_front();
        check("out_instr", 64'(bus.id_instr_o), 64'(e.instr));
        check("out_pc", bus.id_pc_o, e.pc);
        check("out_imm", bus.id_imm_o, e.imm);
        check("out_fmt", 64'(bus.id_fmt_o), 64'(e.fmt));
      end
      if (bus.flush_i) q.delete();
      else if (push_m) q.push_back(model(bus.if_instr_i, bus.if_pc_i));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero_state(input string tag);
    check({tag, "_valid"}, 64'(bus.id_valid_o), 64'd0);
    check({tag, "_ready"}, 64'(bus.if_ready_o), 64'd1);
    check({tag, "_instr"}, 64'(bus.id_instr_o), 64'd0);
    check({tag, "_pc"}, bus.id_pc_o, 64'd0);
    check({tag, "_imm"}, bus.id_imm_o, 64'd0);
    check({tag, "_fmt"}, 64'(bus.id_fmt_o), 64'd0);
  endtask

  initial begin
    logic [6:0]  ops [16];
    logic [31:0] rnd;
    logic [63:0] pc;
    ops = '{7'h03, 7'h13, 7'h1B, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37,
            7'h17, 7'h6F, 7'h33, 7'h3B, 7'h7F, 7'h00, 7'h0F, 7'h2F};
    drive(1'b0, 32'd0, 64'd0);
    bus.flush_i    = 1'b0;
    bus.id_ready_i = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk_en = 1'b1;
    check_zero_state("reset");

    // Decode of load/store/branch with the consumer always ready.
    bus.id_ready_i = 1'b1;
    drive(1'b1, 32'h00813083, 64'h1000);
    cycle();
    check("ld_imm", bus.id_imm_o, 64'h8);
    check("ld_fmt", 64'(bus.id_fmt_o), 64'd1);
    drive(1'b1, 32'hFE113C23, 64'h1004);
    cycle();
    check("sd_imm", bus.id_imm_o, 64'hFFFFFFFFFFFFFFF8);
    check("sd_fmt", 64'(bus.id_fmt_o), 64'd2);
    drive(1'b1, 32'hFE000EE3, 64'h1008);
    cycle();
    check("beq_imm", bus.id_imm_o, 64'hFFFFFFFFFFFFFFFC);
    check("beq_fmt", 64'(bus.id_fmt_o), 64'd3);

    drive(1'b1, 32'h800000B7, 64'h2000);
    cycle();
    check("lui_imm", bus.id_imm_o, 64'hFFFFFFFF80000000);
    check("lui_fmt", 64'(bus.id_fmt_o), 64'd4);
    drive(1'b1, 32'h0010006F, 64'h2004);
    cycle();
    check("jal_imm", bus.id_imm_o, 64'h0000000000000800);
    check("jal_fmt", 64'(bus.id_fmt_o), 64'd5);
    drive(1'b1, 32'h0000007F, 64'h2008);
    cycle();
    check("ill_imm", bus.id_imm_o, 64'd0);
    check("ill_fmt", 64'(bus.id_fmt_o), 64'd7);
    drive(1'b0, 32'd0, 64'd0);
    cycle();

    // Backpressure: two pushes fill the buffer, head holds A.
    bus.id_ready_i = 1'b0;
    drive(1'b1, 32'h00A00093, 64'h3000);
    cycle();
    drive(1'b1, 32'h00B00113, 64'h3004);
    cycle();
    drive(1'b0, 32'd0, 64'd0);
    check("bp_full_ready", 64'(bus.if_ready_o), 64'd0);
    check("bp_head_a", 64'(bus.id_instr_o), 64'h00A00093);
    cycle();
    bus.id_ready_i = 1'b1;
    cycle();
    check("bp_ready_back", 64'(bus.if_ready_o), 64'd1);
    check("bp_head_b", 64'(bus.id_instr_o), 64'h00B00113);
    cycle();
    check("bp_empty", 64'(bus.id_valid_o), 64'd0);

    // Flush while full, with C offered.
    bus.id_ready_i = 1'b0;
    drive(1'b1, 32'h00D00193, 64'h4000);
    cycle();
    drive(1'b1, 32'h00E00213, 64'h4004);
    cycle();
    drive(1'b1, 32'h00C00293, 64'h4008);
    bus.flush_i = 1'b1;
    cycle();
    bus.flush_i = 1'b0;
    drive(1'b0, 32'd0, 64'd0);
    check("flush2_valid", 64'(bus.id_valid_o), 64'd0);
    check("flush2_ready", 64'(bus.if_ready_o), 64'd1);
    bus.id_ready_i = 1'b1;
    cycle();
    cycle();

    // Flush with one entry: the offered word would otherwise be accepted.
    bus.id_ready_i = 1'b0;
    drive(1'b1, 32'h00D00193, 64'h5000);
    cycle();
    drive(1'b1, 32'h00C00293, 64'h5004);
    bus.flush_i = 1'b1;
    cycle();
    bus.flush_i = 1'b0;
    drive(1'b0, 32'd0, 64'd0);
    check("flush1_valid", 64'(bus.id_valid_o), 64'd0);
    check("flush1_ready", 64'(bus.if_ready_o), 64'd1);
    bus.id_ready_i = 1'b1;
    cycle();
    cycle();

    // Reset with two entries held.
    bus.id_ready_i = 1'b0;
    drive(1'b1, 32'h00F00313, 64'h6000);
    cycle();
    drive(1'b1, 32'h01000393, 64'h6004);
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    drive(1'b0, 32'd0, 64'd0);
    check_zero_state("midrst");
    bus.id_ready_i = 1'b1;
    cycle();
    cycle();

    // Random traffic with occasional flush and reset.
    for (int i = 0; i < 10000; i++) begin
      rnd = $urandom();
      pc  = {$urandom(), $urandom()};
      drive(($urandom_range(0, 3) != 0), {rnd[31:7], ops[$urandom_range(0, 15)]}, pc);
      bus.id_ready_i = ($urandom_range(0, 2) != 0);
      bus.flush_i    = ($urandom_range(0, 49) == 0);
      rst            = ($urandom_range(0, 999) == 0);
      cycle();
    end
    rst = 1'b0;
    bus.flush_i = 1'b0;
    bus.id_ready_i = 1'b1;
    drive(1'b0, 32'd0, 64'd0);
    for (int i = 0; i < 4; i++) cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
